// File: rtl/axi_early_wdata_buffer.sv
// AXI write-path adapter: accepts write data ahead of its address (early W)
// and re-orders the stream so the downstream side always sees AW before W.
// AW requests and W beats are buffered in separate FIFOs. W beats are only
// released while at least one downstream AW has an incomplete W burst.
module axi_early_wdata_buffer #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 64,
    parameter int ID_WIDTH        = 3,
    parameter int AW_DEPTH        = 4,
    parameter int W_DEPTH         = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int EARLY_W_EN      = 1
) (
    input  logic                                   aclk,
    input  logic                                   aresetn,
    input  logic                                   s_awvalid,
    output logic                                   s_awready,
    input  logic [ID_WIDTH-1:0]                    s_awid,
    input  logic [ADDR_WIDTH-1:0]                  s_awaddr,
    input  logic [7:0]                             s_awlen,
    input  logic [2:0]                             s_awsize,
    input  logic [1:0]                             s_awburst,
    input  logic                                   s_wvalid,
    output logic                                   s_wready,
    input  logic [DATA_WIDTH-1:0]                  s_wdata,
    input  logic [DATA_WIDTH/8-1:0]                s_wstrb,
    input  logic                                   s_wlast,
    output logic                                   m_awvalid,
    input  logic                                   m_awready,
    output logic [ID_WIDTH-1:0]                    m_awid,
    output logic [ADDR_WIDTH-1:0]                  m_awaddr,
    output logic [7:0]                             m_awlen,
    output logic [2:0]                             m_awsize,
    output logic [1:0]                             m_awburst,
    output logic                                   m_wvalid,
    input  logic                                   m_wready,
    output logic [DATA_WIDTH-1:0]                  m_wdata,
    output logic [DATA_WIDTH/8-1:0]                m_wstrb,
    output logic                                   m_wlast,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   aw_outstanding,
    output logic [$clog2(W_DEPTH+1)-1:0]           w_level,
    output logic                                   wlast_err
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int AW_ENT_W = ID_WIDTH + ADDR_WIDTH + 8 + 3 + 2;
    localparam int W_ENT_W  = DATA_WIDTH + STRB_W + 1;
    localparam int AWP_W    = $clog2(AW_DEPTH);
    localparam int AWC_W    = $clog2(AW_DEPTH + 1);
    localparam int WP_W     = $clog2(W_DEPTH);
    localparam int WC_W     = $clog2(W_DEPTH + 1);
    localparam int OC_W     = $clog2(MAX_OUTSTANDING + 1);
    localparam int LP_W     = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    // Signed: in early mode WLASTs may be accepted before their AW.
    localparam int UP_W     = $clog2(AW_DEPTH + MAX_OUTSTANDING + W_DEPTH + 1) + 1;

    localparam logic signed [UP_W-1:0] UP_ONE = 1;

    // Readies are held low until the first clock edge after reset release.
    logic                   rdy_q;

    logic [AW_ENT_W-1:0]    aw_mem_q [AW_DEPTH];
    logic [AWP_W-1:0]       aw_wptr_q, aw_rptr_q;
    logic [AWC_W-1:0]       aw_cnt_q, aw_cnt_d;

    logic [W_ENT_W-1:0]     w_mem_q [W_DEPTH];
    logic [WP_W-1:0]        w_wptr_q, w_rptr_q;
    logic [WC_W-1:0]        w_cnt_q, w_cnt_d;

    logic [OC_W-1:0]        out_q, out_d;
    logic signed [UP_W-1:0] up_pend_q, up_pend_d;

    logic [7:0]             len_mem_q [MAX_OUTSTANDING];
    logic [LP_W-1:0]        len_wptr_q, len_rptr_q;
    logic [7:0]             len_head;
    logic [7:0]             beat_cnt_q;
    logic                   err_q;
    logic                   len_err;

    logic aw_full, aw_empty, w_full, w_empty, w_mode_ok;
    logic s_aw_hs, s_w_hs, m_aw_hs, m_w_hs, m_wlast_hs;

    function automatic logic [LP_W-1:0] lp_inc(input logic [LP_W-1:0] p);
        return (p == LP_W'(MAX_OUTSTANDING - 1)) ? '0 : p + LP_W'(1);
    endfunction

    assign aw_full   = (aw_cnt_q == AWC_W'(AW_DEPTH));
    assign aw_empty  = (aw_cnt_q == '0);
    assign w_full    = (w_cnt_q == WC_W'(W_DEPTH));
    assign w_empty   = (w_cnt_q == '0);
    assign w_mode_ok = (EARLY_W_EN != 0) || (!up_pend_q[UP_W-1] && (up_pend_q != '0));

    assign s_awready = rdy_q && !aw_full;
    assign s_wready  = rdy_q && !w_full && w_mode_ok;
    assign m_awvalid = !aw_empty && (out_q < OC_W'(MAX_OUTSTANDING));
    assign m_wvalid  = !w_empty && (out_q != '0);

    assign {m_awid, m_awaddr, m_awlen, m_awsize, m_awburst} = aw_mem_q[aw_rptr_q];
    assign {m_wdata, m_wstrb, m_wlast}                       = w_mem_q[w_rptr_q];

    assign s_aw_hs    = s_awvalid && s_awready;
    assign s_w_hs     = s_wvalid && s_wready;
    assign m_aw_hs    = m_awvalid && m_awready;
    assign m_w_hs     = m_wvalid && m_wready;
    assign m_wlast_hs = m_w_hs && m_wlast;

    assign len_head = len_mem_q[len_rptr_q];
    assign len_err  = m_w_hs && (m_wlast ? (beat_cnt_q != len_head) : (beat_cnt_q == len_head));

    assign aw_outstanding = out_q;
    assign w_level        = w_cnt_q;
    assign wlast_err      = err_q;

    // Next-state for occupancy, outstanding and pending-AW counters.
    always_comb begin
        aw_cnt_d  = aw_cnt_q;
        w_cnt_d   = w_cnt_q;
        out_d     = out_q;
        up_pend_d = up_pend_q;
        if (s_aw_hs && !m_aw_hs)      aw_cnt_d = aw_cnt_q + AWC_W'(1);
        else if (!s_aw_hs && m_aw_hs) aw_cnt_d = aw_cnt_q - AWC_W'(1);
        if (s_w_hs && !m_w_hs)        w_cnt_d = w_cnt_q + WC_W'(1);
        else if (!s_w_hs && m_w_hs)   w_cnt_d = w_cnt_q - WC_W'(1);
        if (m_aw_hs && !m_wlast_hs)   out_d = out_q + OC_W'(1);
        else if (!m_aw_hs && m_wlast_hs) out_d = out_q - OC_W'(1);
        if (s_aw_hs && !(s_w_hs && s_wlast))      up_pend_d = up_pend_q + UP_ONE;
        else if (!s_aw_hs && (s_w_hs && s_wlast)) up_pend_d = up_pend_q - UP_ONE;
    end

    // Ready enable, FIFO pointers and counters (control state only).
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rdy_q      <= 1'b0;
            aw_wptr_q  <= '0;
            aw_rptr_q  <= '0;
            aw_cnt_q   <= '0;
            w_wptr_q   <= '0;
            w_rptr_q   <= '0;
            w_cnt_q    <= '0;
            out_q      <= '0;
            up_pend_q  <= '0;
        end else begin
            rdy_q     <= 1'b1;
            aw_cnt_q  <= aw_cnt_d;
            w_cnt_q   <= w_cnt_d;
            out_q     <= out_d;
            up_pend_q <= up_pend_d;
            if (s_aw_hs) aw_wptr_q <= aw_wptr_q + AWP_W'(1);
            if (m_aw_hs) aw_rptr_q <= aw_rptr_q + AWP_W'(1);
            if (s_w_hs)  w_wptr_q  <= w_wptr_q + WP_W'(1);
            if (m_w_hs)  w_rptr_q  <= w_rptr_q + WP_W'(1);
        end
    end

    // FIFO storage; contents are don't-care while empty so no reset needed.
    always_ff @(posedge aclk) begin
        if (s_aw_hs) aw_mem_q[aw_wptr_q] <= {s_awid, s_awaddr, s_awlen, s_awsize, s_awburst};
        if (s_w_hs)  w_mem_q[w_wptr_q]   <= {s_wdata, s_wstrb, s_wlast};
        if (m_aw_hs) len_mem_q[len_wptr_q] <= m_awlen;
    end

    // Burst-length tracking against issued AWLEN and the sticky error flag.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            len_wptr_q <= '0;
            len_rptr_q <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (m_aw_hs)    len_wptr_q <= lp_inc(len_wptr_q);
            if (m_wlast_hs) len_rptr_q <= lp_inc(len_rptr_q);
            if (m_w_hs)     beat_cnt_q <= m_wlast ? 8'd0 : beat_cnt_q + 8'd1;
            if (len_err)    err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_early_wdata_buffer.sv
// Directed bench for axi_early_wdata_buffer: a cycle table for the early-W
// flow plus hand-written sequences for ordering mode, FIFO full, outstanding
// limit, length error and mid-burst reset.
module tb_axi_early_wdata_buffer;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;

    // Instance with early write data enabled (default parameters).
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_wlast;
    logic [2:0]  s_awid, s_awsize;
    logic [31:0] s_awaddr;
    logic [7:0]  s_awlen, s_wstrb;
    logic [1:0]  s_awburst;
    logic [63:0] s_wdata;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_wlast;
    logic [2:0]  m_awid, m_awsize;
    logic [31:0] m_awaddr;
    logic [7:0]  m_awlen, m_wstrb;
    logic [1:0]  m_awburst;
    logic [63:0] m_wdata;
    logic [2:0]  aw_outstanding;
    logic [4:0]  w_level;
    logic        wlast_err;

    // Instance with early write data disabled.
    logic        e_awvalid, e_awready, e_wvalid, e_wready, e_wlast;
    logic [7:0]  e_awlen;
    logic [63:0] e_wdata;
    logic        e_m_awvalid, e_m_wvalid, e_m_wlast;
    logic [2:0]  e_m_awid, e_m_awsize;
    logic [31:0] e_m_awaddr;
    logic [7:0]  e_m_awlen, e_m_wstrb;
    logic [1:0]  e_m_awburst;
    logic [63:0] e_m_wdata;
    logic [2:0]  e_outstanding;
    logic [4:0]  e_level;
    logic        e_err;

    int total = 0;
    int bad   = 0;
    int maw_cnt = 0;
    int mw_cnt  = 0;
    logic [64:0] e_q[$];

    always #5 aclk = ~aclk;

    axi_early_wdata_buffer dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awaddr(s_awaddr),
        .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_wlast(s_wlast),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid), .m_awaddr(m_awaddr),
        .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_wlast(m_wlast),
        .aw_outstanding(aw_outstanding), .w_level(w_level), .wlast_err(wlast_err)
    );

    axi_early_wdata_buffer #(.EARLY_W_EN(0)) dut_ord (
        .aclk(aclk), .aresetn(aresetn),
        .s_awvalid(e_awvalid), .s_awready(e_awready), .s_awid(3'd5), .s_awaddr(32'h1000),
        .s_awlen(e_awlen), .s_awsize(3'd3), .s_awburst(2'd1),
        .s_wvalid(e_wvalid), .s_wready(e_wready), .s_wdata(e_wdata), .s_wstrb(8'hFF),
        .s_wlast(e_wlast),
        .m_awvalid(e_m_awvalid), .m_awready(1'b1), .m_awid(e_m_awid), .m_awaddr(e_m_awaddr),
        .m_awlen(e_m_awlen), .m_awsize(e_m_awsize), .m_awburst(e_m_awburst),
        .m_wvalid(e_m_wvalid), .m_wready(1'b1), .m_wdata(e_m_wdata), .m_wstrb(e_m_wstrb),
        .m_wlast(e_m_wlast),
        .aw_outstanding(e_outstanding), .w_level(e_level), .wlast_err(e_err)
    );

    // Downstream handshake monitors.
    always @(posedge aclk) begin
        if (m_awvalid && m_awready) maw_cnt <= maw_cnt + 1;
        if (m_wvalid && m_wready)   mw_cnt  <= mw_cnt + 1;
        if (e_m_wvalid)             e_q.push_back({e_m_wlast, e_m_wdata});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_aw(input logic [7:0] len);
        int n;
        n = 0;
        @(negedge aclk);
        s_awvalid = 1'b1;
        s_awlen   = len;
        while (!s_awready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        if (!s_awready) chk("push_aw_timeout", 0, 1);
        @(posedge aclk);
        #1 s_awvalid = 1'b0;
    endtask

    task automatic push_w(input logic [63:0] d, input logic last);
        int n;
        n = 0;
        @(negedge aclk);
        s_wvalid = 1'b1;
        s_wdata  = d;
        s_wlast  = last;
        while (!s_wready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        if (!s_wready) chk("push_w_timeout", 0, 1);
        @(posedge aclk);
        #1 s_wvalid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn   = 1'b0;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
    endtask

    typedef struct {
        logic        aw_v;
        logic [7:0]  aw_len;
        logic        w_v;
        logic [63:0] w_data;
        logic        w_last;
        logic        x_awrdy;
        logic        x_wrdy;
        logic        x_mawv;
        logic        x_mwv;
        logic [63:0] x_mwdata;
        logic        x_mwlast;
        logic [2:0]  x_out;
        logic [4:0]  x_wlev;
    } vec_t;

    vec_t tbl[11];

    initial begin
        logic [63:0] d0, d1, d2, d3;
        bit found;
        int base;

        d0 = 64'hD0D0_0000_0000_0000;
        d1 = 64'hD0D0_0000_0000_0001;
        d2 = 64'hD0D0_0000_0000_0002;
        d3 = 64'hD0D0_0000_0000_0003;
        // aw_v len w_v data last | awrdy wrdy mawv mwv mwdata mwlast out wlev
        tbl[0]  = '{1'b0, 8'd0, 1'b1, d0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 3'd0, 5'd0};
        tbl[1]  = '{1'b0, 8'd0, 1'b1, d1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 3'd0, 5'd1};
        tbl[2]  = '{1'b0, 8'd0, 1'b1, d2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 3'd0, 5'd2};
        tbl[3]  = '{1'b0, 8'd0, 1'b1, d3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 3'd0, 5'd3};
        tbl[4]  = '{1'b1, 8'd3, 1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 3'd0, 5'd4};
        tbl[5]  = '{1'b0, 8'd0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'd0, 1'b0, 3'd0, 5'd4};
        tbl[6]  = '{1'b0, 8'd0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, d0, 1'b0, 3'd1, 5'd4};
        tbl[7]  = '{1'b0, 8'd0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, d1, 1'b0, 3'd1, 5'd3};
        tbl[8]  = '{1'b0, 8'd0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, d2, 1'b0, 3'd1, 5'd2};
        tbl[9]  = '{1'b0, 8'd0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, d3, 1'b1, 3'd1, 5'd1};
        tbl[10] = '{1'b0, 8'd0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 3'd0, 5'd0};

        s_awvalid = 0; s_awid = 3'd2; s_awaddr = 32'h8000_0000; s_awlen = 0;
        s_awsize = 3'd3; s_awburst = 2'd1;
        s_wvalid = 0; s_wdata = 0; s_wstrb = 8'hFF; s_wlast = 0;
        m_awready = 1; m_wready = 1;
        e_awvalid = 0; e_awlen = 0; e_wvalid = 0; e_wdata = 0; e_wlast = 0;

        // Reset state.
        repeat (3) @(posedge aclk);
        #1;
        chk("reset_outputs", {s_awready, s_wready, m_awvalid, m_wvalid, aw_outstanding, w_level, wlast_err},
            '0);
        @(negedge aclk);
        aresetn = 1'b1;
        #1 chk("ready_before_first_edge", {s_awready, s_wready}, 2'b00);
        @(posedge aclk);
        #1 chk("ready_after_first_edge", {s_awready, s_wready}, 2'b11);

        // Early W then AW, one cycle per table row.
        for (int i = 0; i < 11; i++) begin
            @(negedge aclk);
            s_awvalid = tbl[i].aw_v;
            s_awlen   = tbl[i].aw_len;
            s_wvalid  = tbl[i].w_v;
            s_wdata   = tbl[i].w_data;
            s_wlast   = tbl[i].w_last;
            #1;
            chk($sformatf("vec%0d_ctrl", i),
                {s_awready, s_wready, m_awvalid, m_wvalid, aw_outstanding, w_level},
                {tbl[i].x_awrdy, tbl[i].x_wrdy, tbl[i].x_mawv, tbl[i].x_mwv, tbl[i].x_out, tbl[i].x_wlev});
            if (tbl[i].x_mwv)
                chk($sformatf("vec%0d_wdata", i), {m_wlast, m_wdata}, {tbl[i].x_mwlast, tbl[i].x_mwdata});
            if (tbl[i].x_mawv)
                chk($sformatf("vec%0d_awlen", i), m_awlen, 8'd3);
        end
        @(negedge aclk);
        s_awvalid = 0; s_wvalid = 0;
        chk("early_no_err", wlast_err, 1'b0);

        // Ordering mode: W waits for its AW.
        @(negedge aclk);
        e_wvalid = 1; e_wdata = 64'hAAAA_0001; e_wlast = 0;
        #1 chk("ord_wready_blocked0", e_wready, 1'b0);
        @(negedge aclk);
        #1 chk("ord_wready_blocked1", e_wready, 1'b0);
        @(negedge aclk);
        e_awvalid = 1; e_awlen = 8'd1;
        #1 chk("ord_aw_cycle", {e_awready, e_wready}, 2'b10);
        @(posedge aclk);
        #1 e_awvalid = 0;
        chk("ord_wready_after_aw", {e_wready, e_m_awvalid}, 2'b11);
        @(posedge aclk);
        #1 e_wdata = 64'hAAAA_0002; e_wlast = 1;
        chk("ord_wready_beat2", e_wready, 1'b1);
        @(posedge aclk);
        #1 e_wvalid = 0;
        chk("ord_wready_after_last", e_wready, 1'b0);
        repeat (6) @(posedge aclk);
        #1 chk("ord_beat_count", e_q.size(), 2);
        if (e_q.size() == 2) begin
            chk("ord_beat0", e_q[0], {1'b0, 64'hAAAA_0001});
            chk("ord_beat1", e_q[1], {1'b1, 64'hAAAA_0002});
        end

        // W FIFO full with downstream stalled.
        do_reset();
        m_wready = 0;
        push_aw(8'd15);
        for (int i = 0; i < 16; i++) push_w(64'h100 + 64'(i), i == 15);
        chk("full_level", {w_level, s_wready}, {5'd16, 1'b0});
        @(negedge aclk);
        s_wvalid = 1; s_wdata = 64'h200; s_wlast = 1;
        #1 chk("full_17th_blocked", s_wready, 1'b0);
        @(negedge aclk);
        m_wready = 1;
        #1 chk("full_no_bypass", {s_wready, m_wvalid}, 2'b01);
        @(posedge aclk);
        #1 m_wready = 0;
        chk("full_ready_back", {s_wready, w_level}, {1'b1, 5'd15});
        @(posedge aclk);
        #1 s_wvalid = 0;
        chk("full_refilled", {s_wready, w_level}, {1'b0, 5'd16});

        // Outstanding limit.
        do_reset();
        m_wready = 0;
        base = maw_cnt;
        for (int i = 0; i < 6; i++) push_aw(8'd0);
        repeat (3) @(posedge aclk);
        #1 chk("limit_aw_count", maw_cnt - base, 4);
        chk("limit_state", {m_awvalid, aw_outstanding}, {1'b0, 3'd4});
        m_wready = 1;
        push_w(64'h300, 1'b1);
        repeat (4) @(posedge aclk);
        #1 chk("limit_fifth_aw", maw_cnt - base, 5);
        chk("limit_outst_after", aw_outstanding, 3'd4);

        // Length error: len 3 but WLAST on the third beat.
        do_reset();
        m_wready = 1;
        push_w(64'h400, 1'b0);
        push_w(64'h401, 1'b0);
        push_w(64'h402, 1'b1);
        push_aw(8'd3);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge aclk);
            if (m_wvalid && m_wlast) begin
                found = 1;
                chk("lenerr_before", wlast_err, 1'b0);
                @(posedge aclk);
                #1 chk("lenerr_set", wlast_err, 1'b1);
            end
        end
        if (!found) chk("lenerr_wlast_timeout", 0, 1);
        push_aw(8'd1);
        push_w(64'h500, 1'b0);
        push_w(64'h501, 1'b1);
        repeat (5) @(posedge aclk);
        #1 chk("lenerr_sticky", {wlast_err, aw_outstanding}, {1'b1, 3'd0});

        // Reset in the middle of a burst (sticky error still set).
        m_wready = 0;
        push_aw(8'd3);
        for (int i = 0; i < 4; i++) push_w(64'h600 + 64'(i), i == 3);
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        m_wready = 1;
        @(posedge aclk);
        @(posedge aclk);
        #1 chk("mid_two_sent", {m_wvalid, w_level, wlast_err}, {1'b1, 5'd2, 1'b1});
        #2;
        aresetn = 0;
        m_wready = 0;
        base = mw_cnt;
        #1 chk("mid_reset_outputs",
               {s_awready, s_wready, m_awvalid, m_wvalid, aw_outstanding, w_level, wlast_err}, '0);
        m_wready = 1;
        repeat (3) @(posedge aclk);
        #1 chk("mid_no_beats_in_reset", mw_cnt - base, 0);
        @(negedge aclk);
        aresetn = 1;
        #1 chk("mid_ready_low_at_release", s_awready, 1'b0);
        @(posedge aclk);
        #1 chk("mid_ready_after_edge", {s_awready, m_wvalid, w_level}, {1'b1, 1'b0, 5'd0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
